rot_scheduler: RTL and testbench

Sequencer for the shared row-rotation pipeline in the 4x4 MIMO QR path. For each column k = 0..3, it issues rows k..3 back-to-back into the rotation unit. It tracks each in-flight row with a tag delay line matched to the unit's fixed latency and raises write-back strobes when results emerge. Between columns it hands off to the downstream combine stage with a req/ack handshake.

---
 rtl/rot_scheduler_pkg.sv | 21 ++
 rtl/rot_tag_pipe.sv | 30 +++
 rtl/rot_scheduler.sv | 108 ++++++++++
 tb/tb_rot_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_scheduler_pkg.sv
// Shared types and constants for the QR row-rotation scheduler.
package rot_scheduler_pkg;

    // Default latency of the rotation unit, which has two pipeline registers.
    localparam int ROT_LAT = 2;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_ISSUE,
        RS_DRAIN,
        RS_WAIT,
        RS_FIN
    } rs_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic [1:0] col;
    } rot_tag_t;

endpackage

// File: rtl/rot_tag_pipe.sv
// Tag delay line that follows each issued row through the rotation unit.
module rot_tag_pipe
    import rot_scheduler_pkg::*;
#(
    parameter int LAT = ROT_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  rot_tag_t head,
    output rot_tag_t tail
);

    rot_tag_t stages [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= head;
            for (int i = 1; i < LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tail = stages[LAT-1];

endmodule

// File: rtl/rot_scheduler.sv
// Column-by-column issue sequencer for the shared rotation unit, with
// write-back tagging and a req/ack hand-off to the combine stage.
module rot_scheduler
    import rot_scheduler_pkg::*;
#(
    parameter int NROW = 4,
    parameter int LAT  = ROT_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       iss_valid,
    output logic [1:0] iss_row,
    output logic [1:0] iss_col,
    output logic       wb_en,
    output logic [1:0] wb_row,
    output logic [1:0] wb_col,
    output logic       cmb_req,
    output logic [1:0] cmb_col,
    input  logic       cmb_ack
);

    localparam logic [1:0] LAST = 2'(NROW - 1);

    rs_state_t  state, state_nxt;
    logic [1:0] row, row_nxt;
    logic [1:0] col, col_nxt;
    rot_tag_t   issue_tag;
    rot_tag_t   wb_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RS_IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        issue_tag = '0;
        busy      = 1'b1;
        done      = 1'b0;
        cmb_req   = 1'b0;
        cmb_col   = '0;
        case (state)
            RS_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = RS_ISSUE;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            RS_ISSUE: begin
                issue_tag.valid = 1'b1;
                issue_tag.row   = row;
                issue_tag.col   = col;
                row_nxt         = row + 2'd1;
                if (row == LAST) state_nxt = RS_DRAIN;
            end
            RS_DRAIN: begin
                // Earlier columns are fully drained, so any row-3 result here is ours.
                if (wb_tag.valid && wb_tag.row == LAST)
                    state_nxt = (col == LAST) ? RS_FIN : RS_WAIT;
            end
            RS_WAIT: begin
                cmb_req = 1'b1;
                cmb_col = col;
                if (cmb_ack) begin
                    col_nxt   = col + 2'd1;
                    row_nxt   = col + 2'd1;
                    state_nxt = RS_ISSUE;
                end
            end
            RS_FIN: begin
                done      = 1'b1;
                row_nxt   = '0;
                col_nxt   = '0;
                state_nxt = RS_IDLE;
            end
            default: state_nxt = RS_IDLE;
        endcase
    end

    rot_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .head (issue_tag),
        .tail (wb_tag)
    );

    assign iss_valid = issue_tag.valid;
    assign iss_row   = issue_tag.row;
    assign iss_col   = issue_tag.col;
    assign wb_en     = wb_tag.valid;
    assign wb_row    = wb_tag.row;
    assign wb_col    = wb_tag.col;

endmodule

// File: tb/tb_rot_scheduler.sv
// Directed bench for rot_scheduler: LAT=2 unit under handshake scenarios,
// plus a LAT=5 unit with combine ack tied high.
module tb_rot_scheduler;

    localparam int NCYC = 40;

    logic clk = 1'b0;
    logic rst, start, cmb_ack;

    logic       busy, done, iss_valid, wb_en, cmb_req;
    logic [1:0] iss_row, iss_col, wb_row, wb_col, cmb_col;
    logic       busy5, done5, iss_valid5, wb_en5, cmb_req5;
    logic [1:0] iss_row5, iss_col5, wb_row5, wb_col5, cmb_col5;

    int total = 0;
    int bad   = 0;
    int rec[$];
    int rec5[$];
    int exp_q[$];
    int busy_cnt, busy_cnt5, wb_cnt;

    always #5 clk = ~clk;

    rot_scheduler #(.NROW(4), .LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .iss_valid(iss_valid), .iss_row(iss_row), .iss_col(iss_col),
        .wb_en(wb_en), .wb_row(wb_row), .wb_col(wb_col),
        .cmb_req(cmb_req), .cmb_col(cmb_col), .cmb_ack(cmb_ack)
    );

    rot_scheduler #(.NROW(4), .LAT(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .busy(busy5), .done(done5),
        .iss_valid(iss_valid5), .iss_row(iss_row5), .iss_col(iss_col5),
        .wb_en(wb_en5), .wb_row(wb_row5), .wb_col(wb_col5),
        .cmb_req(cmb_req5), .cmb_col(cmb_col5), .cmb_ack(1'b1)
    );

    // Event code: kind 1=issue 2=writeback 3=cmb_req 4=done
    function automatic int code(input int k, input int c, input int r, input int cl);
        return k * 10000 + c * 100 + r * 10 + cl;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 drives start; cycle c is the period after the c-th edge following it.
    task automatic run_pass(input int hold0, input logic [63:0] st_mask, input logic [63:0] ak_mask);
        int reqcnt;
        rec.delete();
        rec5.delete();
        busy_cnt = 0; busy_cnt5 = 0; wb_cnt = 0; reqcnt = 0;
        for (int c = 0; c <= NCYC; c++) begin
            if (c > 0) begin
                if (iss_valid) rec.push_back(code(1, c, int'(iss_row), int'(iss_col)));
                if (wb_en)     rec.push_back(code(2, c, int'(wb_row), int'(wb_col)));
                if (cmb_req)   rec.push_back(code(3, c, 0, int'(cmb_col)));
                if (done)      rec.push_back(code(4, c, 0, 0));
                if (busy)      busy_cnt++;
                if (wb_en)     wb_cnt++;
                if (iss_valid5) rec5.push_back(code(1, c, int'(iss_row5), int'(iss_col5)));
                if (wb_en5)     rec5.push_back(code(2, c, int'(wb_row5), int'(wb_col5)));
                if (cmb_req5)   rec5.push_back(code(3, c, 0, int'(cmb_col5)));
                if (done5)      rec5.push_back(code(4, c, 0, 0));
                if (busy5)      busy_cnt5++;
            end
            if (cmb_req) reqcnt++;
            else         reqcnt = 0;
            cmb_ack = (cmb_req && reqcnt >= ((cmb_col == 2'd0) ? hold0 : 1)) || ak_mask[c];
            start   = (c == 0) || st_mask[c];
            step();
        end
        start   = 1'b0;
        cmb_ack = 1'b0;
    endtask

    task automatic build_exp(input int lat, input int ic[10], input int rc[3], input int hold0, input int dc);
        int rows[10];
        int cols[10];
        rows = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
        cols = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        exp_q.delete();
        for (int c = 1; c <= NCYC; c++) begin
            for (int i = 0; i < 10; i++) if (ic[i] == c) exp_q.push_back(code(1, c, rows[i], cols[i]));
            for (int i = 0; i < 10; i++) if (ic[i] + lat == c) exp_q.push_back(code(2, c, rows[i], cols[i]));
            for (int j = 0; j < 3; j++) begin
                if (c >= rc[j] && c < rc[j] + ((j == 0) ? hold0 : 1)) exp_q.push_back(code(3, c, 0, j));
            end
            if (dc == c) exp_q.push_back(code(4, c, 0, 0));
        end
    endtask

    task automatic nominal_exp();
        int ic[10];
        int rc[3];
        ic = '{1, 2, 3, 4, 8, 9, 10, 14, 15, 19};
        rc = '{7, 13, 18};
        build_exp(2, ic, rc, 1, 22);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cmb_ack = 1'b0;
        step(); step();
        total++;
        if ({busy, done, iss_valid, iss_row, iss_col, wb_en, wb_row, wb_col, cmb_req, cmb_col} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, done, iss_valid, iss_row, iss_col, wb_en, wb_row, wb_col, cmb_req, cmb_col});
        end
        rst = 1'b0;
        step();
        total++;
        if ({busy, iss_valid, wb_en, busy5} !== 4'd0) begin
            bad++;
            $display("FAIL reset_release_idle got=%b want=0000", {busy, iss_valid, wb_en, busy5});
        end
    endtask

    task automatic test_nominal();
        run_pass(1, '0, '0);
        nominal_exp();
        total++;
        if (rec.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL nominal_events got=%0d want=%0d", rec.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rec.size(); i++) begin
            total++;
            if (rec[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL nominal_ev%0d got=%0d want=%0d", i, rec[i], exp_q[i]);
            end
        end
        total++;
        if (wb_cnt !== 10) begin
            bad++;
            $display("FAIL nominal_wb_count got=%0d want=10", wb_cnt);
        end
        total++;
        if (busy_cnt !== 22) begin
            bad++;
            $display("FAIL nominal_busy_cycles got=%0d want=22", busy_cnt);
        end
    endtask

    task automatic test_cmb_stall();
        int ic[10];
        int rc[3];
        run_pass(5, '0, '0);
        ic = '{1, 2, 3, 4, 12, 13, 14, 18, 19, 23};
        rc = '{7, 17, 22};
        build_exp(2, ic, rc, 5, 26);
        total++;
        if (rec.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL stall_events got=%0d want=%0d", rec.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rec.size(); i++) begin
            total++;
            if (rec[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_ev%0d got=%0d want=%0d", i, rec[i], exp_q[i]);
            end
        end
        total++;
        if (busy_cnt !== 26) begin
            bad++;
            $display("FAIL stall_busy_cycles got=%0d want=26", busy_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] sm;
        sm = '0;
        sm[2] = 1'b1;
        sm[9] = 1'b1;
        run_pass(1, sm, '0);
        nominal_exp();
        total++;
        if (rec.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL restart_events got=%0d want=%0d", rec.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rec.size(); i++) begin
            total++;
            if (rec[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL restart_ev%0d got=%0d want=%0d", i, rec[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int act;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, iss_valid, iss_row, iss_col, wb_en, wb_row, wb_col, cmb_req, cmb_col} !== 15'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {busy, done, iss_valid, iss_row, iss_col, wb_en, wb_row, wb_col, cmb_req, cmb_col});
        end
        total++;
        if ({busy5, iss_valid5, wb_en5} !== 3'd0) begin
            bad++;
            $display("FAIL midreset_outputs_lat5 got=%b want=000", {busy5, iss_valid5, wb_en5});
        end
        step();
        rst = 1'b0;
        act = 0;
        for (int c = 0; c < 20; c++) begin
            if (wb_en || iss_valid || done || cmb_req || busy || wb_en5 || done5) act++;
            step();
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL midreset_quiet got=%0d active cycles want=0", act);
        end
        run_pass(1, '0, '0);
        nominal_exp();
        total++;
        if (rec.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL midreset_events got=%0d want=%0d", rec.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rec.size(); i++) begin
            total++;
            if (rec[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_ev%0d got=%0d want=%0d", i, rec[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_lat5();
        int ic[10];
        int rc[3];
        run_pass(1, '0, '0);
        ic = '{1, 2, 3, 4, 11, 12, 13, 20, 21, 28};
        rc = '{10, 19, 27};
        build_exp(5, ic, rc, 1, 34);
        total++;
        if (rec5.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL lat5_events got=%0d want=%0d", rec5.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rec5.size(); i++) begin
            total++;
            if (rec5[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL lat5_ev%0d got=%0d want=%0d", i, rec5[i], exp_q[i]);
            end
        end
        total++;
        if (busy_cnt5 !== 34) begin
            bad++;
            $display("FAIL lat5_busy_cycles got=%0d want=34", busy_cnt5);
        end
    endtask

    task automatic test_stray_ack();
        logic [63:0] am;
        am = '0;
        am[0]  = 1'b1;
        am[2]  = 1'b1;
        am[3]  = 1'b1;
        am[9]  = 1'b1;
        am[25] = 1'b1;
        am[30] = 1'b1;
        run_pass(1, '0, am);
        nominal_exp();
        total++;
        if (rec.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL strayack_events got=%0d want=%0d", rec.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rec.size(); i++) begin
            total++;
            if (rec[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL strayack_ev%0d got=%0d want=%0d", i, rec[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_cmb_stall();
        test_start_while_busy();
        test_reset_mid_pass();
        test_lat5();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
